// File: rtl/mlp_io_pkg.sv
// Shared types, default sizes and helpers for the MLP sample sequencer.
package mlp_io_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    EMIT    = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_NUM_FEAT   = 4;
  localparam int unsigned DEF_FEAT_W     = 4;
  localparam int unsigned DEF_CLS_W      = 2;
  localparam int unsigned DEF_SETTLE_CYC = 2;
  localparam int unsigned DEF_CNT_W      = 16;

  // Bits needed to hold the settle down-counter load value SETTLE_CYC-1.
  function automatic int unsigned settle_cnt_w(input int unsigned settle_cyc);
    return (settle_cyc <= 1) ? 1 : $clog2(settle_cyc);
  endfunction

endpackage

// File: rtl/mlp_sample_sequencer_if.sv
// Feature and result valid/ready streams of the sample sequencer.
interface mlp_sample_sequencer_if
  import mlp_io_pkg::*;
#(
  parameter int unsigned FEAT_W = DEF_FEAT_W,
  parameter int unsigned CLS_W  = DEF_CLS_W
) ();

  logic              feat_valid;
  logic              feat_ready;
  logic [FEAT_W-1:0] feat_data;
  logic [CLS_W-1:0]  lbl_data;

  logic              res_valid;
  logic              res_ready;
  logic [CLS_W-1:0]  res_class;
  logic              res_err;

  // Producer of features and consumer of results.
  modport master (
    output feat_valid, feat_data, lbl_data, res_ready,
    input  feat_ready, res_valid, res_class, res_err
  );

  // The sequencer side.
  modport slave (
    input  feat_valid, feat_data, lbl_data, res_ready,
    output feat_ready, res_valid, res_class, res_err
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a dominant synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear beats increment; hold at all-ones once reached.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mlp_sample_sequencer.sv
// Packs feature beats into the classifier input, waits for the classifier to settle,
// captures and checks its class, and returns the result with running counters.
module mlp_sample_sequencer
  import mlp_io_pkg::*;
#(
  parameter int unsigned NUM_FEAT   = DEF_NUM_FEAT,
  parameter int unsigned FEAT_W     = DEF_FEAT_W,
  parameter int unsigned CLS_W      = DEF_CLS_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  mlp_sample_sequencer_if.slave      bus,
  output logic [NUM_FEAT*FEAT_W-1:0] cls_inp,
  input  logic [CLS_W-1:0]           cls_out,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int unsigned IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned SCNT_W = settle_cnt_w(SETTLE_CYC);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_FEAT - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);

  seq_state_e        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SCNT_W-1:0] settle_q;
  logic [CLS_W-1:0]  label_q;

  logic feat_fire;
  logic res_fire;

  assign feat_fire = bus.feat_valid & bus.feat_ready;
  assign res_fire  = bus.res_valid & bus.res_ready;

  // Sequencer FSM; every output it drives is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= COLLECT;
      idx_q          <= '0;
      settle_q       <= '0;
      label_q        <= '0;
      cls_inp        <= '0;
      bus.feat_ready <= 1'b1;
      bus.res_valid  <= 1'b0;
      bus.res_class  <= '0;
      bus.res_err    <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (feat_fire) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
              if (idx_q == IDX_W'(k)) begin
                cls_inp[k*FEAT_W +: FEAT_W] <= bus.feat_data;
              end
            end
            if (idx_q == LAST_IDX) begin
              label_q        <= bus.lbl_data;
              idx_q          <= '0;
              settle_q       <= SETTLE_LOAD;
              bus.feat_ready <= 1'b0;
              state_q        <= SETTLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        SETTLE: begin
          if (settle_q == '0) begin
            // Out-of-range classes never equal a legal label, so they count as errors.
            bus.res_class <= cls_out;
            bus.res_err   <= (cls_out != label_q);
            bus.res_valid <= 1'b1;
            state_q       <= EMIT;
          end else begin
            settle_q <= settle_q - SCNT_W'(1);
          end
        end

        EMIT: begin
          if (res_fire) begin
            bus.res_valid  <= 1'b0;
            bus.feat_ready <= 1'b1;
            state_q        <= COLLECT;
          end
        end

        default: begin
          state_q        <= COLLECT;
          idx_q          <= '0;
          bus.feat_ready <= 1'b1;
          bus.res_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Results delivered.
  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (res_fire),
    .cnt (sample_cnt)
  );

  // Results delivered with a class/label mismatch.
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (res_fire & bus.res_err),
    .cnt (err_cnt)
  );

endmodule
